// File: rtl/secuenciador_motores_if.sv
// Control and motor bus of the motor dosing sequencer.
interface secuenciador_motores_if #(
    parameter int N_CH  = 3,
    parameter int CNT_W = 5
);
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                    start;
    logic                    pause;
    logic                    abort;
    logic [N_CH*CNT_W-1:0]   ciclos;
    logic [N_CH-1:0]         ch_en;
    logic [N_CH-1:0]         motores;
    logic [N_CH-1:0]         flags;
    logic [CW-1:0]           canal;
    logic                    ocupado;
    logic                    done;

    modport master (
        output start, pause, abort, ciclos, ch_en,
        input  motores, flags, canal, ocupado, done
    );

    modport slave (
        input  start, pause, abort, ciclos, ch_en,
        output motores, flags, canal, ocupado, done
    );
endinterface

// File: rtl/secuenciador_motores.sv
// N-channel motor dosing sequencer: sequential or parallel,
// with pause, abort, channel mask and sticky done flags.
module secuenciador_motores #(
    parameter int N_CH     = 3,
    parameter int CNT_W    = 5,
    parameter int TICK_DIV = 1,
    parameter int MODE     = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    secuenciador_motores_if.slave   bus
);
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_PAUSA, S_DONE
    } st_t;

    st_t                          r_st;
    st_t                          w_st_n;
    logic [N_CH-1:0][CNT_W-1:0]   r_cnt;
    logic [N_CH-1:0][CNT_W-1:0]   w_cnt_n;
    logic [PW-1:0]                r_pre;
    logic [PW-1:0]                w_pre_n;
    logic [N_CH-1:0]              r_flags;
    logic [N_CH-1:0]              w_flags_n;
    logic [N_CH-1:0]              r_mot;
    logic [CW-1:0]                r_canal;
    logic                         r_ocup;
    logic                         r_done;
    logic                         w_tick;
    logic [N_CH-1:0]              w_nz;
    logic [N_CH-1:0]              w_oh;
    logic [CW-1:0]                w_idx;

    always_comb begin
        w_tick    = (r_pre == PW'(TICK_DIV - 1));
        w_st_n    = r_st;
        w_cnt_n   = r_cnt;
        w_pre_n   = r_pre;
        w_flags_n = r_flags;
        unique case (r_st)
            S_IDLE: begin
                if (bus.start) w_st_n = S_LOAD;
            end
            S_LOAD: begin
                w_st_n    = S_RUN;
                w_pre_n   = '0;
                w_flags_n = '0;
                for (int k = 0; k < N_CH; k++) begin
                    w_cnt_n[k] = bus.ch_en[k] ?
                        bus.ciclos[k*CNT_W +: CNT_W] : '0;
                end
            end
            S_RUN: begin
                // pause wins over tick: no decrement that cycle
                if (bus.pause) begin
                    w_st_n = S_PAUSA;
                end else begin
                    w_pre_n = w_tick ? '0 : r_pre + PW'(1);
                    if (w_tick) begin
                        if (MODE != 0) begin
                            for (int k = 0; k < N_CH; k++) begin
                                if (r_cnt[k] != '0)
                                    w_cnt_n[k] = r_cnt[k] - CNT_W'(1);
                            end
                        end else begin
                            w_cnt_n[r_canal] = r_cnt[r_canal] - CNT_W'(1);
                        end
                    end
                end
            end
            S_PAUSA: begin
                if (!bus.pause) w_st_n = S_RUN;
            end
            S_DONE: begin
                w_st_n = S_IDLE;
            end
            default: begin
                w_st_n = S_IDLE;
            end
        endcase

        for (int k = 0; k < N_CH; k++) w_nz[k] = |w_cnt_n[k];

        if (r_st == S_LOAD || r_st == S_RUN) begin
            w_flags_n = w_flags_n | ~w_nz;
            if (w_nz == '0) w_st_n = S_DONE;
        end

        if (bus.abort && r_st != S_IDLE) begin
            w_st_n    = S_IDLE;
            w_cnt_n   = '0;
            w_pre_n   = '0;
            w_flags_n = r_flags;
            w_nz      = '0;
        end

        // lowest pending channel, as one-hot and as index
        w_oh  = w_nz & (~w_nz + N_CH'(1));
        w_idx = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (w_nz[k]) w_idx = CW'(k);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_st    <= S_IDLE;
            r_cnt   <= '0;
            r_pre   <= '0;
            r_flags <= '0;
            r_mot   <= '0;
            r_canal <= '0;
            r_ocup  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_st    <= w_st_n;
            r_cnt   <= w_cnt_n;
            r_pre   <= w_pre_n;
            r_flags <= w_flags_n;
            r_ocup  <= (w_st_n != S_IDLE);
            r_done  <= (w_st_n == S_DONE);
            if (w_st_n == S_RUN)
                r_mot <= (MODE != 0) ? w_nz : w_oh;
            else
                r_mot <= '0;
            if (MODE == 0 && (w_st_n == S_RUN || w_st_n == S_PAUSA))
                r_canal <= w_idx;
            else
                r_canal <= '0;
        end
    end

    assign bus.motores = r_mot;
    assign bus.flags   = r_flags;
    assign bus.canal   = r_canal;
    assign bus.ocupado = r_ocup;
    assign bus.done    = r_done;
endmodule

// File: tb/tb_secuenciador_motores.sv
// Directed bench: per-cycle vector table plus hand-written
// parallel, pause, max-count and async-reset sequences.
module tb_secuenciador_motores;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    secuenciador_motores_if #(.N_CH(3), .CNT_W(5)) b0 ();
    secuenciador_motores_if #(.N_CH(3), .CNT_W(5)) b1 ();
    secuenciador_motores_if #(.N_CH(3), .CNT_W(5)) b2 ();

    secuenciador_motores #(.N_CH(3), .CNT_W(5), .TICK_DIV(1), .MODE(0))
        u0 (.clk(clk), .reset(rst_n), .bus(b0.slave));
    secuenciador_motores #(.N_CH(3), .CNT_W(5), .TICK_DIV(4), .MODE(1))
        u1 (.clk(clk), .reset(rst_n), .bus(b1.slave));
    secuenciador_motores #(.N_CH(3), .CNT_W(5), .TICK_DIV(2), .MODE(0))
        u2 (.clk(clk), .reset(rst_n), .bus(b2.slave));

    typedef struct {
        logic        st;
        logic        ab;
        logic [14:0] cic;
        logic [2:0]  en;
        logic [9:0]  exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic s, logic a, logic [14:0] c,
                               logic [2:0] e, logic [2:0] m,
                               logic [2:0] f, logic [1:0] cn,
                               logic o, logic d);
        vec_t r;
        r.st  = s;
        r.ab  = a;
        r.cic = c;
        r.en  = e;
        r.exp = {m, f, cn, o, d};
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    localparam logic [14:0] C321 = {5'd1, 5'd2, 5'd3};
    localparam logic [14:0] C250 = {5'd0, 5'd5, 5'd2};
    localparam logic [14:0] C000 = 15'd0;
    localparam logic [14:0] C777 = {5'd7, 5'd7, 5'd7};

    initial begin
        logic [9:0] act;
        logic [31:0] exp_m;
        logic [31:0] exp_f;
        int on_cnt;
        int done_at;
        logic pz;

        {b0.start, b0.pause, b0.abort, b0.ciclos, b0.ch_en} = '0;
        {b1.start, b1.pause, b1.abort, b1.ciclos, b1.ch_en} = '0;
        {b2.start, b2.pause, b2.abort, b2.ciclos, b2.ch_en} = '0;

        // sequential 3,2,1
        tbl.push_back(v(1, 0, C321, 7, 3'b000, 3'b000, 0, 0, 0));
        tbl.push_back(v(0, 0, C321, 7, 3'b000, 3'b000, 0, 1, 0));
        tbl.push_back(v(0, 0, C321, 7, 3'b001, 3'b000, 0, 1, 0));
        tbl.push_back(v(0, 0, C321, 7, 3'b001, 3'b000, 0, 1, 0));
        tbl.push_back(v(0, 0, C321, 7, 3'b001, 3'b000, 0, 1, 0));
        tbl.push_back(v(0, 0, C321, 7, 3'b010, 3'b001, 1, 1, 0));
        tbl.push_back(v(0, 0, C321, 7, 3'b010, 3'b001, 1, 1, 0));
        tbl.push_back(v(0, 0, C321, 7, 3'b100, 3'b011, 2, 1, 0));
        tbl.push_back(v(0, 0, C321, 7, 3'b000, 3'b111, 0, 1, 1));
        tbl.push_back(v(0, 0, C321, 7, 3'b000, 3'b111, 0, 0, 0));
        // mask 101, counts 2,5,0
        tbl.push_back(v(1, 0, C250, 5, 3'b000, 3'b111, 0, 0, 0));
        tbl.push_back(v(0, 0, C250, 5, 3'b000, 3'b111, 0, 1, 0));
        tbl.push_back(v(0, 0, C250, 5, 3'b001, 3'b110, 0, 1, 0));
        tbl.push_back(v(0, 0, C250, 5, 3'b001, 3'b110, 0, 1, 0));
        tbl.push_back(v(0, 0, C250, 5, 3'b000, 3'b111, 0, 1, 1));
        tbl.push_back(v(0, 0, C250, 5, 3'b000, 3'b111, 0, 0, 0));
        // all counts zero
        tbl.push_back(v(1, 0, C000, 7, 3'b000, 3'b111, 0, 0, 0));
        tbl.push_back(v(0, 0, C000, 7, 3'b000, 3'b111, 0, 1, 0));
        tbl.push_back(v(0, 0, C000, 7, 3'b000, 3'b111, 0, 1, 1));
        tbl.push_back(v(0, 0, C000, 7, 3'b000, 3'b111, 0, 0, 0));
        // abort on channel 1
        tbl.push_back(v(1, 0, C321, 7, 3'b000, 3'b111, 0, 0, 0));
        tbl.push_back(v(0, 0, C321, 7, 3'b000, 3'b111, 0, 1, 0));
        tbl.push_back(v(0, 0, C321, 7, 3'b001, 3'b000, 0, 1, 0));
        tbl.push_back(v(0, 0, C321, 7, 3'b001, 3'b000, 0, 1, 0));
        tbl.push_back(v(0, 0, C321, 7, 3'b001, 3'b000, 0, 1, 0));
        tbl.push_back(v(0, 1, C321, 7, 3'b010, 3'b001, 1, 1, 0));
        tbl.push_back(v(0, 0, C321, 7, 3'b000, 3'b001, 0, 0, 0));
        // restart; start while busy and late ciclos change ignored
        tbl.push_back(v(1, 0, C321, 7, 3'b000, 3'b001, 0, 0, 0));
        tbl.push_back(v(0, 0, C321, 7, 3'b000, 3'b001, 0, 1, 0));
        tbl.push_back(v(1, 0, C777, 2, 3'b001, 3'b000, 0, 1, 0));
        tbl.push_back(v(0, 0, C777, 2, 3'b001, 3'b000, 0, 1, 0));
        tbl.push_back(v(1, 0, C777, 2, 3'b001, 3'b000, 0, 1, 0));
        tbl.push_back(v(0, 0, C777, 2, 3'b010, 3'b001, 1, 1, 0));
        tbl.push_back(v(0, 0, C777, 2, 3'b010, 3'b001, 1, 1, 0));
        tbl.push_back(v(0, 0, C777, 2, 3'b100, 3'b011, 2, 1, 0));
        tbl.push_back(v(0, 0, C777, 2, 3'b000, 3'b111, 0, 1, 1));
        tbl.push_back(v(0, 0, C777, 2, 3'b000, 3'b111, 0, 0, 0));

        repeat (2) @(negedge clk);
        chk("reset_u0", {b0.motores, b0.flags, b0.canal,
                         b0.ocupado, b0.done}, 32'd0);
        chk("reset_u1", {b1.motores, b1.flags, b1.ocupado, b1.done}, 32'd0);
        chk("reset_u2", {b2.motores, b2.flags, b2.ocupado, b2.done}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            b0.start  = tbl[i].st;
            b0.abort  = tbl[i].ab;
            b0.ciclos = tbl[i].cic;
            b0.ch_en  = tbl[i].en;
            act = {b0.motores, b0.flags, b0.canal, b0.ocupado, b0.done};
            chk($sformatf("vec%0d", i), act, tbl[i].exp);
        end
        @(negedge clk);
        b0.start = 0;
        b0.abort = 0;

        // parallel, TICK_DIV=4, counts 1,3,2
        b1.ciclos = {5'd2, 5'd3, 5'd1};
        b1.ch_en  = 3'b111;
        b1.start  = 1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            b1.start = 0;
            exp_m = (c < 2) ? 0 : (c < 6) ? 7 : (c < 10) ? 6 :
                    (c < 14) ? 2 : 0;
            exp_f = (c < 6) ? 0 : (c < 10) ? 1 : (c < 14) ? 5 : 7;
            chk($sformatf("par_c%0d", c),
                {b1.motores, b1.flags, b1.canal, b1.done},
                {exp_m[2:0], exp_f[2:0], 2'd0, 1'(c == 14)});
        end

        // pause on channel 1, count 4, TICK_DIV=2
        b2.ciclos = {5'd0, 5'd4, 5'd0};
        b2.ch_en  = 3'b010;
        b2.start  = 1;
        on_cnt = 0;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            b2.start = 0;
            pz = (c >= 5 && c <= 9);
            b2.pause = pz;
            if (b2.motores != 0 && !pz) on_cnt++;
            exp_m = ((c >= 2 && c <= 5) || (c >= 11 && c <= 15)) ? 2 : 0;
            chk($sformatf("pau_c%0d", c),
                {b2.motores, b2.canal, b2.done},
                {exp_m[2:0], (c >= 2 && c <= 15) ? 2'd1 : 2'd0,
                 1'(c == 16)});
        end
        chk("pau_ontime", on_cnt, 8);

        // max count 31 on channel 0
        b0.ciclos = {5'd0, 5'd0, 5'd31};
        b0.ch_en  = 3'b001;
        b0.start  = 1;
        on_cnt  = 0;
        done_at = -1;
        for (int c = 1; c <= 60 && done_at < 0; c++) begin
            @(negedge clk);
            b0.start = 0;
            if (b0.motores == 3'b001) on_cnt++;
            if (b0.done) done_at = c;
        end
        chk("max_ontime", on_cnt, 31);
        chk("max_done_at", done_at, 33);
        chk("max_flags", b0.flags, 3'b111);

        // async reset in the middle of a run
        @(negedge clk);
        b0.ciclos = C321;
        b0.ch_en  = 3'b111;
        b0.start  = 1;
        repeat (3) @(negedge clk);
        b0.start = 0;
        chk("pre_rst_busy", {b0.motores, b0.ocupado}, 4'b0011);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", {b0.motores, b0.flags, b0.canal,
                          b0.ocupado, b0.done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", {b0.motores, b0.ocupado, b0.done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/secuenciador_motores.md
Name: secuenciador_motores

Overview:
Parametrised successor to the three-motor dosing timer. It drives N_CH motor outputs for per-channel cycle counts, each cycle lasting TICK_DIV clocks. It supports sequential or parallel dosing, pause/resume, abort, a channel-enable mask and per-channel completion flags. It sits between the RGB memory (count source) and the motor pins, replacing the fixed Temporizador/FSM pair.

Parameters:
N_CH, 3, number of motor channels (>=1)
CNT_W, 5, width of each channel cycle count
TICK_DIV, 1, clocks per dosing tick (>=1)
MODE, 0, 0 = sequential (one motor at a time, channel 0 first), 1 = parallel (all motors at once)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  synchronous one-cycle start pulse (debounced enter)
pause  in  1  level; freezes dosing while high
abort  in  1  pulse; cancels the run
ciclos  in  N_CH*CNT_W  packed counts; channel k = ciclos[k*CNT_W +: CNT_W]
ch_en  in  N_CH  channel enable mask
motores  out  N_CH  motor drive, registered
flags  out  N_CH  sticky per-channel done flags
canal  out  max(1,clog2(N_CH))  active channel index (sequential); 0 in parallel
ocupado  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset (async, reset=0): state IDLE; motores=0, flags=0, canal=0, ocupado=0, done=0; counters and prescaler cleared.
- States: IDLE, LOAD, RUN, PAUSA, DONE.
- IDLE: start=1 -> LOAD. start is ignored in all other states.
- LOAD (1 cycle): latch each channel count (ch_en[k]=0 forces 0); clear flags; clear prescaler. Channels with latched count 0 are marked done immediately (flag set in the first RUN cycle). If all counts are 0 -> DONE, otherwise -> RUN.
- RUN: the prescaler counts 0..TICK_DIV-1; tick = prescaler==TICK_DIV-1.
  - Sequential: canal = lowest-index pending channel; motores = one-hot(canal). On each tick, decrement that channel's counter. The tick that brings it to 0 sets flags[canal]. In the next cycle canal advances to the next pending channel, with no gap cycle and the prescaler restarting at 0. If no pending channel remains -> DONE.
  - Parallel: motores[k]=1 for every channel with counter>0. Each tick decrements all nonzero counters. Flags are set as counters reach 0. When all counters are 0 -> DONE.
  - Channel k motor-on time = count_k*TICK_DIV clocks exactly.
- Latency: start at cycle t; LOAD at t+1; motores first asserted at t+2.
- PAUSA: entered from RUN when pause=1, evaluated before tick. motores=0; prescaler and counters frozen; flags held. pause=0 -> RUN in the next cycle with the same channel and prescaler value.
- DONE (1 cycle): done=1, motores=0 -> IDLE. flags remain set until the next LOAD.
- abort has highest priority in LOAD/RUN/PAUSA/DONE: next cycle IDLE, motores=0, no done pulse, flags hold their partial values.
- Simultaneous events: abort > pause > tick. A pause and tick in the same cycle means no decrement.
- ciclos/ch_en changes after LOAD have no effect until the next start.
- Counters are unsigned CNT_W bits; the maximum count 2^CNT_W-1 is honoured with no wrap.

Test Plan:
- Sequential, TICK_DIV=1, ciclos R=3,G=2,B=1, ch_en=111, start -> motores 001 for 3 clk, 010 for 2, 100 for 1, contiguous from t+2; flags=111; done pulse at t+8.
- Sequential, ch_en=101, counts 2,5,0 -> only ch0 runs 2 clk; flags=111 (ch1 masked, ch2 zero); done at t+4.
- Parallel, TICK_DIV=4, counts 1,3,2 -> motores 111 for 4 clk, 110 for 4, 010 for 4; flags set at clk 4, 8, 12 of RUN; done next cycle.
- Pause: sequential, count 4, TICK_DIV=2, pause high 5 clk mid-run -> motores 0 during pause; total on-time still 8 clk; canal unchanged.
- Abort during RUN on channel 1 -> IDLE next clk, motores=000, done never pulses, flags=001; a new start reloads and clears flags.
- All counts 0 / start while busy / async reset mid-RUN -> immediate DONE pulse at t+2 / start ignored / all outputs 0 asynchronously.
